module_control_operacion: RTL and testbench
===========================================

Name: module_control_operacion

Overview:
- Sequencing controller between the keypad decoder and the arithmetic unit.
- Accepts decoded key events and assembles two decimal operands.
- Issues a one-cycle start to the operation unit, waits for completion with a timeout, and latches the result.
- Selects the value shown on the display. Sits in module_top between the keypad block and the operation/display blocks.

Parameters:
WIDTH, 8, operand width in bits; result is 2*WIDTH
N_DIGITS, 2, max decimal digits per operand; 10^N_DIGITS-1 must fit in WIDTH (elaboration-time check)
TIMEOUT, 64, max cycles to wait for op_done after op_start

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
key_valid  in  1  one-cycle pulse per decoded keypress
key_code  in  4  0-9 digit, 4'hA enter, 4'hC clear, others ignored
op_done  in  1  operation unit completion pulse
op_result  in  2*WIDTH  operation unit result, valid with op_done
first_num  out  WIDTH  first operand (binary)
second_num  out  WIDTH  second operand (binary)
op_start  out  1  one-cycle start pulse to operation unit
ready_1  out  1  first operand committed
ready_2  out  1  second operand committed
ready  out  1  result valid
error  out  1  operation timed out
disp_value  out  2*WIDTH  value for display block

Behaviour:
- One clock domain, clk; reset is synchronous, active-high on rst.
- rst=1 at a rising edge:
  - all outputs go to 0 (disp_value=0);
  - digit count and timeout counter go to 0;
  - state goes to ENTER_A.
  - rst overrides every other input, including mid-WAIT.
- States: ENTER_A, ENTER_B, START, WAIT, SHOW, ERROR.
- All outputs are registered. Key effects are visible the edge after the key_valid cycle.
- Digit key in ENTER_A or ENTER_B, when count < N_DIGITS:
  - the active operand becomes operand*10 + digit, computed in WIDTH+4 bits and truncated to WIDTH;
  - count increments.
- Digits beyond N_DIGITS are ignored, and the operand is unchanged.
- 4'hA in ENTER_A with count>=1: ready_1<=1, count<=0, next state ENTER_B.
- 4'hA in ENTER_B with count>=1: ready_2<=1, next state START.
- 4'hA with count=0 is ignored.
- Keys B, D, E, F are ignored in all states.
- START lasts exactly one cycle with op_start=1, then WAIT; the timeout counter is cleared on entry to WAIT.
- WAIT:
  - op_done=1 latches op_result, sets ready<=1, next state SHOW;
  - otherwise the counter increments;
  - when the counter reaches TIMEOUT-1 with no op_done: error<=1, next state ERROR;
  - op_done and timeout in the same cycle: op_done wins.
- op_done outside WAIT is ignored; the result register is unchanged.
- Digit and enter keys are ignored in START, WAIT, SHOW and ERROR.
- 4'hC in any state clears everything to reset values and goes to ENTER_A on the next edge.
  - In WAIT, C wins over a simultaneous op_done: the result is not latched and ready stays 0.
- disp_value by state:
  - ENTER_A: zero-extended first_num;
  - ENTER_B, START, WAIT: zero-extended second_num;
  - SHOW: latched result;
  - ERROR: all ones.
- ready_1, ready_2 and ready are levels: they hold until C or rst.
- op_start is never asserted outside START, and never twice per operation.

Test Plan:
1. Reset 200 cycles, then keys 1,2,A,3,4,A; op_done with op_result=408 five cycles after op_start:
   - first_num=12, ready_1=1; second_num=34, ready_2=1;
   - exactly one op_start pulse;
   - ready=1, disp_value=408, state SHOW.
2. Keys 1,2,5,A:
   - first_num=12; third digit ignored; ready_1=1.
3. Key A with no digits, then B, D, E, F:
   - no change: ready_1=0, first_num=0, state ENTER_A.
4. TIMEOUT=16, complete entry, op_done never asserted:
   - error=1 and disp_value=16'hFFFF exactly 16 cycles after op_start;
   - a later op_done is ignored;
   - key C returns everything to 0 and state to ENTER_A.
5. Key C mid ENTER_B (after digit 3), and separately C coinciding with op_done in WAIT:
   - all operands and flags cleared, ready=0, disp_value=0, ENTER_A.
6. rst=1 for one cycle during WAIT:
   - all outputs 0 on the next edge;
   - op_done the following cycle is ignored;
   - new entry 7,A is accepted (first_num=7).

Source files
------------

// File: rtl/module_control_operacion.sv
// Keypad-to-ALU sequencer: assembles two decimal operands, starts the
// operation unit, waits for completion with a timeout and selects the display.
module module_control_operacion #(
    parameter int WIDTH    = 8,
    parameter int N_DIGITS = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    input  logic                 op_done,
    input  logic [2*WIDTH-1:0]   op_result,
    output logic [WIDTH-1:0]     first_num,
    output logic [WIDTH-1:0]     second_num,
    output logic                 op_start,
    output logic                 ready_1,
    output logic                 ready_2,
    output logic                 ready,
    output logic                 error,
    output logic [2*WIDTH-1:0]   disp_value
);

    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] NDIG = CW'(N_DIGITS);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    if ((10 ** N_DIGITS) - 1 >= (2 ** WIDTH)) begin : g_width_check
        $error("N_DIGITS decimal digits do not fit in WIDTH bits");
    end

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        START,
        WAIT,
        SHOW,
        ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [WIDTH-1:0]     first_q, first_d;
    logic [WIDTH-1:0]     second_q, second_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [2*WIDTH-1:0]   disp_q, disp_d;
    logic                 op_start_q, op_start_d;
    logic                 ready_1_q, ready_1_d;
    logic                 ready_2_q, ready_2_d;
    logic                 ready_q, ready_d;
    logic                 error_q, error_d;

    logic                 is_digit;
    logic                 is_enter;
    logic                 is_clear;
    logic                 can_digit;
    logic [WIDTH+3:0]     mac_a;
    logic [WIDTH+3:0]     mac_b;
    logic [TW-1:0]        timer_inc;

    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_enter  = key_valid && (key_code == 4'hA);
    assign is_clear  = key_valid && (key_code == 4'hC);
    assign can_digit = is_digit && (count_q < NDIG);
    assign timer_inc = timer_q + TW'(1);

    // operand*10 + digit as (x<<3)+(x<<1), widened by 4 bits before truncation
    assign mac_a = ({4'b0000, first_q} << 3) + ({4'b0000, first_q} << 1)
                 + {{WIDTH{1'b0}}, key_code};
    assign mac_b = ({4'b0000, second_q} << 3) + ({4'b0000, second_q} << 1)
                 + {{WIDTH{1'b0}}, key_code};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        timer_d    = timer_q;
        first_d    = first_q;
        second_d   = second_q;
        result_d   = result_q;
        op_start_d = 1'b0;
        ready_1_d  = ready_1_q;
        ready_2_d  = ready_2_q;
        ready_d    = ready_q;
        error_d    = error_q;

        case (state_q)
            ENTER_A: begin
                if (can_digit) begin
                    first_d = mac_a[WIDTH-1:0];
                    count_d = count_q + CW'(1);
                end else if (is_enter && (count_q != '0)) begin
                    ready_1_d = 1'b1;
                    count_d   = '0;
                    state_d   = ENTER_B;
                end
            end
            ENTER_B: begin
                if (can_digit) begin
                    second_d = mac_b[WIDTH-1:0];
                    count_d  = count_q + CW'(1);
                end else if (is_enter && (count_q != '0)) begin
                    ready_2_d  = 1'b1;
                    op_start_d = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (op_done) begin
                    result_d = op_result;
                    ready_d  = 1'b1;
                    state_d  = SHOW;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TLIM) begin
                        error_d = 1'b1;
                        state_d = ERROR;
                    end
                end
            end
            SHOW, ERROR: begin
            end
            default: state_d = ENTER_A;
        endcase

        // clear key and reset share one path and beat any simultaneous op_done
        if (rst || is_clear) begin
            state_d    = ENTER_A;
            count_d    = '0;
            timer_d    = '0;
            first_d    = '0;
            second_d   = '0;
            result_d   = '0;
            op_start_d = 1'b0;
            ready_1_d  = 1'b0;
            ready_2_d  = 1'b0;
            ready_d    = 1'b0;
            error_d    = 1'b0;
        end

        case (state_d)
            ENTER_A:             disp_d = {{WIDTH{1'b0}}, first_d};
            ENTER_B, START, WAIT: disp_d = {{WIDTH{1'b0}}, second_d};
            SHOW:                disp_d = result_d;
            ERROR:               disp_d = '1;
            default:             disp_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        count_q    <= count_d;
        timer_q    <= timer_d;
        first_q    <= first_d;
        second_q   <= second_d;
        result_q   <= result_d;
        disp_q     <= disp_d;
        op_start_q <= op_start_d;
        ready_1_q  <= ready_1_d;
        ready_2_q  <= ready_2_d;
        ready_q    <= ready_d;
        error_q    <= error_d;
    end

    assign first_num  = first_q;
    assign second_num = second_q;
    assign op_start   = op_start_q;
    assign ready_1    = ready_1_q;
    assign ready_2    = ready_2_q;
    assign ready      = ready_q;
    assign error      = error_q;
    assign disp_value = disp_q;

endmodule

// File: tb/tb_module_control_operacion.sv
// Directed bench for module_control_operacion (TIMEOUT=16 instance).
module tb_module_control_operacion;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        op_done = 1'b0;
    logic [15:0] op_result = 16'h0;
    logic [7:0]  first_num;
    logic [7:0]  second_num;
    logic        op_start;
    logic        ready_1;
    logic        ready_2;
    logic        ready;
    logic        error;
    logic [15:0] disp_value;

    int tests = 0;
    int fails = 0;
    int n_starts = 0;

    module_control_operacion #(
        .WIDTH(8),
        .N_DIGITS(2),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_valid(key_valid),
        .key_code(key_code),
        .op_done(op_done),
        .op_result(op_result),
        .first_num(first_num),
        .second_num(second_num),
        .op_start(op_start),
        .ready_1(ready_1),
        .ready_2(ready_2),
        .ready(ready),
        .error(error),
        .disp_value(disp_value)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (op_start) n_starts++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    function automatic logic [44:0] all_out();
        return {first_num, second_num, op_start, ready_1, ready_2,
                ready, error, disp_value};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (200) tick();
        rst = 1'b0;
        tests++;
        if (all_out() !== 45'h0) begin
            $display("FAIL reset_outputs got=%h exp=0", all_out());
            fails++;
        end
    endtask

    task automatic test_basic();
        int base;
        base = n_starts;
        press(4'h1);
        press(4'h2);
        tests++;
        if (first_num !== 8'd12 || disp_value !== 16'd12) begin
            $display("FAIL basic_first got=%0d/%0d exp=12/12", first_num, disp_value);
            fails++;
        end
        press(4'hA);
        tests++;
        if (ready_1 !== 1'b1 || disp_value !== 16'd0) begin
            $display("FAIL basic_ready1 got=%b/%0d exp=1/0", ready_1, disp_value);
            fails++;
        end
        press(4'h3);
        press(4'h4);
        tests++;
        if (second_num !== 8'd34 || disp_value !== 16'd34) begin
            $display("FAIL basic_second got=%0d/%0d exp=34/34", second_num, disp_value);
            fails++;
        end
        press(4'hA);
        tests++;
        if (ready_2 !== 1'b1 || op_start !== 1'b1) begin
            $display("FAIL basic_start got=%b/%b exp=1/1", ready_2, op_start);
            fails++;
        end
        repeat (5) tick();
        tests++;
        if (op_start !== 1'b0 || ready !== 1'b0) begin
            $display("FAIL basic_wait got=%b/%b exp=0/0", op_start, ready);
            fails++;
        end
        op_done   = 1'b1;
        op_result = 16'd408;
        tick();
        op_done   = 1'b0;
        op_result = 16'd0;
        repeat (3) tick();
        tests++;
        if (ready !== 1'b1 || disp_value !== 16'd408) begin
            $display("FAIL basic_result got=%b/%0d exp=1/408", ready, disp_value);
            fails++;
        end
        tests++;
        if (n_starts - base !== 1) begin
            $display("FAIL basic_one_start got=%0d exp=1", n_starts - base);
            fails++;
        end
        press(4'hC);
    endtask

    task automatic test_third_digit();
        press(4'h1);
        press(4'h2);
        press(4'h5);
        press(4'hA);
        tests++;
        if (first_num !== 8'd12 || ready_1 !== 1'b1) begin
            $display("FAIL third_digit got=%0d/%b exp=12/1", first_num, ready_1);
            fails++;
        end
        press(4'hC);
    endtask

    task automatic test_ignored();
        press(4'hA);
        press(4'hB);
        press(4'hD);
        press(4'hE);
        press(4'hF);
        tests++;
        if (all_out() !== 45'h0) begin
            $display("FAIL ignored_keys got=%h exp=0", all_out());
            fails++;
        end
        press(4'h7);
        tests++;
        if (first_num !== 8'd7 || disp_value !== 16'd7) begin
            $display("FAIL ignored_still_a got=%0d/%0d exp=7/7", first_num, disp_value);
            fails++;
        end
        press(4'hC);
    endtask

    task automatic test_timeout();
        int base;
        base = n_starts;
        press(4'h1);
        press(4'hA);
        press(4'h2);
        press(4'hA);
        repeat (15) tick();
        tests++;
        if (error !== 1'b0 || disp_value !== 16'd2) begin
            $display("FAIL timeout_early got=%b/%0d exp=0/2", error, disp_value);
            fails++;
        end
        tick();
        tests++;
        if (error !== 1'b1 || disp_value !== 16'hFFFF) begin
            $display("FAIL timeout_hit got=%b/%h exp=1/ffff", error, disp_value);
            fails++;
        end
        op_done   = 1'b1;
        op_result = 16'd5;
        tick();
        op_done   = 1'b0;
        tick();
        tests++;
        if (ready !== 1'b0 || disp_value !== 16'hFFFF || n_starts - base !== 1) begin
            $display("FAIL timeout_late_done got=%b/%h/%0d exp=0/ffff/1",
                     ready, disp_value, n_starts - base);
            fails++;
        end
        press(4'hC);
        tests++;
        if (all_out() !== 45'h0) begin
            $display("FAIL timeout_clear got=%h exp=0", all_out());
            fails++;
        end
    endtask

    task automatic test_clear();
        press(4'h1);
        press(4'hA);
        press(4'h3);
        press(4'hC);
        tests++;
        if (all_out() !== 45'h0) begin
            $display("FAIL clear_enter_b got=%h exp=0", all_out());
            fails++;
        end
        press(4'h1);
        press(4'hA);
        press(4'h2);
        press(4'hA);
        tick();
        op_done   = 1'b1;
        op_result = 16'd77;
        press(4'hC);
        op_done   = 1'b0;
        op_result = 16'd0;
        tests++;
        if (all_out() !== 45'h0) begin
            $display("FAIL clear_vs_done got=%h exp=0", all_out());
            fails++;
        end
    endtask

    task automatic test_reset_wait();
        press(4'h4);
        press(4'hA);
        press(4'h5);
        press(4'hA);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (all_out() !== 45'h0) begin
            $display("FAIL rst_in_wait got=%h exp=0", all_out());
            fails++;
        end
        op_done   = 1'b1;
        op_result = 16'd99;
        tick();
        op_done   = 1'b0;
        op_result = 16'd0;
        tests++;
        if (ready !== 1'b0 || disp_value !== 16'd0) begin
            $display("FAIL rst_late_done got=%b/%0d exp=0/0", ready, disp_value);
            fails++;
        end
        press(4'h7);
        press(4'hA);
        tests++;
        if (first_num !== 8'd7 || ready_1 !== 1'b1) begin
            $display("FAIL rst_new_entry got=%0d/%b exp=7/1", first_num, ready_1);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_third_digit();
        test_ignored();
        test_timeout();
        test_clear();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
